// File: rtl/wr_decoder_sb.sv
`default_nettype none
// ============================================================================
// Module      : wr_decoder_sb
// Description : Register-file write-enable decoder with an issue scoreboard.
//               Tracks one pending-write bit per architectural register,
//               gates instruction issue on RAW/WAW hazards (with same-cycle
//               write-back bypass), and turns each write-back into a
//               registered one-hot write enable one cycle later.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   AW        register-address width; N = 2**AW registers
//   ZERO_REG  1: register 0 is hardwired (never decoded, never busy)
// Ports
//   clk          in   1     rising-edge clock
//   rst_n        in   1     asynchronous active-low reset
//   issue_valid  in   1     an instruction writing issue_addr requests issue
//   issue_addr   in   AW    destination register of the issuing instruction
//   src_a/src_b  in   AW    source registers of the issuing instruction
//   issue_ready  out  1     combinational: issuing instruction has no hazard
//   wb_valid     in   1     a write-back is presented this cycle
//   wb_addr      in   AW    write-back destination register
//   we           out  N     registered one-hot register-file write enable
//   busy         out  N     registered scoreboard (bit i = write pending)
//   pend_cnt     out  AW+1  registered popcount of busy
//   err          out  1     sticky: write-back hit a register not busy
// ============================================================================
module wr_decoder_sb #(
  parameter int AW       = 5,
  parameter int ZERO_REG = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                issue_valid,
  input  logic [AW-1:0]       issue_addr,
  input  logic [AW-1:0]       src_a,
  input  logic [AW-1:0]       src_b,
  output logic                issue_ready,
  input  logic                wb_valid,
  input  logic [AW-1:0]       wb_addr,
  output logic [(1<<AW)-1:0]  we,
  output logic [(1<<AW)-1:0]  busy,
  output logic [AW:0]         pend_cnt,
  output logic                err
);

  localparam int N = 1 << AW;

  localparam logic [N-1:0] c_one       = {{(N-1){1'b0}}, 1'b1};
  // Bits that may ever be decoded: everything, or everything but register 0.
  localparam logic [N-1:0] c_keep_mask = (ZERO_REG != 0) ? ~c_one : {N{1'b1}};

  logic [N-1:0] busy_q, busy_d;
  logic [N-1:0] we_q, we_d;
  logic [AW:0]  pend_cnt_q, pend_cnt_d;
  logic         err_q, err_d;

  logic [N-1:0] w_wb_onehot;
  logic [N-1:0] w_issue_onehot;
  logic [N-1:0] w_effbusy;
  logic         w_accept;
  logic         w_wb_err;

  // Write-back decode. Masking register 0 here means a hardwired-zero
  // write-back neither pulses we nor counts as a spurious write-back.
  assign w_wb_onehot = wb_valid ? ((c_one << wb_addr) & c_keep_mask) : '0;

  // A register retiring this very cycle is already safe to read or rewrite,
  // so its busy bit is hidden from the hazard check (write-back bypass).
  assign w_effbusy = busy_q & ~w_wb_onehot & c_keep_mask;

  // Deliberately independent of issue_valid so upstream can look ahead.
  assign issue_ready = ~w_effbusy[src_a] & ~w_effbusy[src_b] & ~w_effbusy[issue_addr];

  assign w_accept       = issue_valid & issue_ready;
  assign w_issue_onehot = w_accept ? ((c_one << issue_addr) & c_keep_mask) : '0;

  // Any write-back bit that lands on a non-pending register is an error.
  assign w_wb_err = |(w_wb_onehot & ~busy_q);

  always_comb begin
    busy_d     = busy_q;
    we_d       = '0;
    err_d      = err_q;
    pend_cnt_d = '0;

    // Clear first, then set: an issue and a write-back to the same register
    // in one cycle leaves the bit pending for the new instruction.
    busy_d = (busy_q & ~w_wb_onehot) | w_issue_onehot;
    we_d   = w_wb_onehot;
    err_d  = err_q | w_wb_err;

    // Counting the next-state vector keeps pend_cnt exactly equal to
    // popcount(busy) in every cycle, so it can never drift or wrap.
    for (int i = 0; i < N; i++) begin
      pend_cnt_d = pend_cnt_d + {{AW{1'b0}}, busy_d[i]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q     <= '0;
      we_q       <= '0;
      pend_cnt_q <= '0;
      err_q      <= 1'b0;
    end else begin
      busy_q     <= busy_d;
      we_q       <= we_d;
      pend_cnt_q <= pend_cnt_d;
      err_q      <= err_d;
    end
  end

  assign busy     = busy_q;
  assign we       = we_q;
  assign pend_cnt = pend_cnt_q;
  assign err      = err_q;

endmodule
`default_nettype wire

// File: tb/tb_wr_decoder_sb.sv
`default_nettype none
// ============================================================================
// Module      : tb_wr_decoder_sb
// Description : Self-checking bench for wr_decoder_sb. Directed vector table,
//               randomized traffic against a register-array reference model,
//               and multi-cycle reset corner sequences on a second, small
//               instance (AW=3, ZERO_REG=0).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wr_decoder_sb;

  localparam int AW  = 5;
  localparam int N   = 32;
  localparam int AW3 = 3;
  localparam int N3  = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // main instance (defaults: AW=5, ZERO_REG=1)
  logic          rst_n;
  logic          issue_valid;
  logic [AW-1:0] issue_addr, src_a, src_b;
  logic          issue_ready;
  logic          wb_valid;
  logic [AW-1:0] wb_addr;
  logic [N-1:0]  we, busy;
  logic [AW:0]   pend_cnt;
  logic          err;

  // small instance
  logic           rst_n3;
  logic           issue_valid3;
  logic [AW3-1:0] issue_addr3, src_a3, src_b3;
  logic           issue_ready3;
  logic           wb_valid3;
  logic [AW3-1:0] wb_addr3;
  logic [N3-1:0]  we3, busy3;
  logic [AW3:0]   pend_cnt3;
  logic           err3;

  wr_decoder_sb #(.AW(AW), .ZERO_REG(1)) dut (
    .clk(clk), .rst_n(rst_n),
    .issue_valid(issue_valid), .issue_addr(issue_addr),
    .src_a(src_a), .src_b(src_b), .issue_ready(issue_ready),
    .wb_valid(wb_valid), .wb_addr(wb_addr),
    .we(we), .busy(busy), .pend_cnt(pend_cnt), .err(err)
  );

  wr_decoder_sb #(.AW(AW3), .ZERO_REG(0)) dut3 (
    .clk(clk), .rst_n(rst_n3),
    .issue_valid(issue_valid3), .issue_addr(issue_addr3),
    .src_a(src_a3), .src_b(src_b3), .issue_ready(issue_ready3),
    .wb_valid(wb_valid3), .wb_addr(wb_addr3),
    .we(we3), .busy(busy3), .pend_cnt(pend_cnt3), .err(err3)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (main instance, ZERO_REG=1) ------------
  bit m_busy[N];
  bit m_err;

  function automatic void m_clear();
    for (int i = 0; i < N; i++) m_busy[i] = 1'b0;
    m_err = 1'b0;
  endfunction

  // A register blocks issue if it is pending, is not being written back right
  // now, and is not the hardwired zero register.
  function automatic bit m_blocks(int r, bit wv, int wa);
    return m_busy[r] && !(wv && wa == r) && (r != 0);
  endfunction

  function automatic logic [N-1:0] m_busy_vec();
    logic [N-1:0] v = '0;
    for (int i = 0; i < N; i++) v[i] = m_busy[i];
    return v;
  endfunction

  function automatic int m_count();
    int c = 0;
    for (int i = 0; i < N; i++) c += int'(m_busy[i]);
    return c;
  endfunction

  // Called at a negedge; returns at the following negedge.
  task automatic mstep(input bit iv, input int ia, input int sa, input int sb,
                       input bit wv, input int wa);
    bit           rdy;
    logic [N-1:0] exp_we;
    logic [N-1:0] one = 1;
    issue_valid = iv; issue_addr = ia[AW-1:0];
    src_a = sa[AW-1:0]; src_b = sb[AW-1:0];
    wb_valid = wv; wb_addr = wa[AW-1:0];
    #1;
    rdy = !m_blocks(sa, wv, wa) && !m_blocks(sb, wv, wa) && !m_blocks(ia, wv, wa);
    chk("rnd_issue_ready", issue_ready, rdy);
    exp_we = (wv && wa != 0) ? (one << wa) : '0;
    if (wv && wa != 0 && !m_busy[wa]) m_err = 1'b1;
    if (wv) m_busy[wa] = 1'b0;
    if (iv && rdy && ia != 0) m_busy[ia] = 1'b1;
    @(posedge clk); #2;
    chk("rnd_busy", busy, m_busy_vec());
    chk("rnd_we", we, exp_we);
    chk("rnd_pend_cnt", pend_cnt, m_count());
    chk("rnd_err", err, m_err);
    @(negedge clk);
  endtask

  // ---------------- directed vector table ----------------------------------
  typedef struct {
    bit          iv;
    int          ia, sa, sb;
    bit          wv;
    int          wa;
    bit          rdy;
    logic [31:0] busy;
    logic [31:0] we;
    int          cnt;
    bit          err;
  } vec_t;

  vec_t tbl[$];

  initial begin
    //                iv ia sa sb wv wa rdy busy           we          cnt err
    tbl.push_back('{1, 5, 1, 2, 0, 0, 1, 32'h0000_0020, 32'h0,       1, 0}); // issue dst 5
    tbl.push_back('{1, 6, 5, 0, 0, 0, 0, 32'h0000_0020, 32'h0,       1, 0}); // RAW on 5
    tbl.push_back('{1, 7, 5, 1, 1, 5, 1, 32'h0000_0080, 32'h20,      1, 0}); // bypass wb 5
    tbl.push_back('{0, 0, 0, 0, 0, 0, 1, 32'h0000_0080, 32'h0,       1, 0}); // idle
    tbl.push_back('{1, 9, 0, 0, 0, 0, 1, 32'h0000_0280, 32'h0,       2, 0}); // issue dst 9
    tbl.push_back('{1, 9, 1, 2, 0, 0, 0, 32'h0000_0280, 32'h0,       2, 0}); // WAW on 9
    tbl.push_back('{1, 9, 1, 2, 1, 9, 1, 32'h0000_0280, 32'h200,     2, 0}); // set wins
    tbl.push_back('{1, 0, 0, 0, 0, 0, 1, 32'h0000_0280, 32'h0,       2, 0}); // dst 0 ignored
    tbl.push_back('{0, 0, 0, 0, 1, 0, 1, 32'h0000_0280, 32'h0,       2, 0}); // wb 0 ignored
    tbl.push_back('{0, 0, 0, 0, 1, 7, 1, 32'h0000_0200, 32'h80,      1, 0}); // retire 7
    tbl.push_back('{0, 0, 0, 0, 1, 3, 1, 32'h0000_0200, 32'h8,       1, 1}); // wb non-busy
    tbl.push_back('{0, 0, 0, 0, 0, 0, 1, 32'h0000_0200, 32'h0,       1, 1}); // err held
    tbl.push_back('{0, 0, 0, 0, 1, 9, 1, 32'h0000_0000, 32'h200,     0, 1}); // retire 9
    tbl.push_back('{1,31,30,29, 1, 7, 1, 32'h8000_0000, 32'h80,      1, 1}); // b2b we
    tbl.push_back('{0,31, 0, 0, 0, 0, 0, 32'h8000_0000, 32'h0,       1, 1}); // WAW on 31
  end

  // ---------------- main sequence ------------------------------------------
  initial begin
    int iv, ia, sa, sb, wv, wa;

    rst_n = 1'b1; rst_n3 = 1'b1;
    issue_valid = 0; issue_addr = '0; src_a = '0; src_b = '0;
    wb_valid = 0; wb_addr = '0;
    issue_valid3 = 0; issue_addr3 = '0; src_a3 = '0; src_b3 = '0;
    wb_valid3 = 0; wb_addr3 = '0;

    // Asynchronous reset before the first clock edge.
    #2; rst_n = 1'b0; rst_n3 = 1'b0;
    #1;
    chk("reset_busy", busy, 0);
    chk("reset_we", we, 0);
    chk("reset_pend_cnt", pend_cnt, 0);
    chk("reset_err", err, 0);

    // Inputs are ignored while reset is held.
    issue_valid = 1; issue_addr = 5'd5; wb_valid = 1; wb_addr = 5'd3;
    @(posedge clk); @(posedge clk); #2;
    chk("inrst_busy", busy, 0);
    chk("inrst_we", we, 0);
    chk("inrst_err", err, 0);

    @(negedge clk);
    rst_n = 1'b1; rst_n3 = 1'b1;
    issue_valid = 0; wb_valid = 0;
    for (int k = 0; k < 4; k++) begin
      issue_addr = AW'($urandom_range(0, N-1));
      src_a      = AW'($urandom_range(0, N-1));
      src_b      = AW'($urandom_range(0, N-1));
      #1;
      chk("post_reset_ready", issue_ready, 1);
    end
    @(negedge clk);

    // Directed vectors.
    for (int k = 0; k < tbl.size(); k++) begin
      issue_valid = tbl[k].iv; issue_addr = AW'(tbl[k].ia);
      src_a = AW'(tbl[k].sa); src_b = AW'(tbl[k].sb);
      wb_valid = tbl[k].wv; wb_addr = AW'(tbl[k].wa);
      #1;
      chk($sformatf("vec%0d_ready", k), issue_ready, tbl[k].rdy);
      @(posedge clk); #2;
      chk($sformatf("vec%0d_busy", k), busy, tbl[k].busy);
      chk($sformatf("vec%0d_we", k), we, tbl[k].we);
      chk($sformatf("vec%0d_pend_cnt", k), pend_cnt, tbl[k].cnt);
      chk($sformatf("vec%0d_err", k), err, tbl[k].err);
      @(negedge clk);
    end

    // Mid-cycle asynchronous reset clears sticky err and busy.
    issue_valid = 0; wb_valid = 0;
    #2; rst_n = 1'b0; #1;
    chk("async_rst_busy", busy, 0);
    chk("async_rst_err", err, 0);
    chk("async_rst_pend_cnt", pend_cnt, 0);
    @(negedge clk); rst_n = 1'b1;
    m_clear();

    // Randomized traffic, addresses biased to a small window for hazards.
    for (int k = 0; k < 1500; k++) begin
      iv = ($urandom_range(0, 3) != 0);
      ia = ($urandom_range(0, 7) == 0) ? $urandom_range(0, N-1) : $urandom_range(0, 11);
      sa = $urandom_range(0, 11);
      sb = ($urandom_range(0, 7) == 0) ? $urandom_range(0, N-1) : $urandom_range(0, 11);
      wv = ($urandom_range(0, 2) != 0);
      wa = ($urandom_range(0, 15) == 0) ? $urandom_range(0, N-1) : $urandom_range(0, 11);
      mstep(iv[0], ia, sa, sb, wv[0], wa);
    end

    // Reset landing inside a we pulse suppresses it.
    mstep(1'b0, 0, 0, 0, 1'b0, 0);
    wb_valid = 1; wb_addr = 5'd4; issue_valid = 1; issue_addr = 5'd4;
    @(posedge clk); #2;
    wb_valid = 0; issue_valid = 0;
    rst_n = 1'b0; #1;
    chk("rst_mid_we", we, 0);
    chk("rst_mid_busy", busy, 0);
    @(negedge clk); rst_n = 1'b1;

    // Small instance: fill every register, including register 0.
    @(negedge clk);
    for (int d = 0; d < N3; d++) begin
      issue_valid3 = 1; issue_addr3 = AW3'(d); src_a3 = AW3'(d); src_b3 = AW3'(d);
      #1;
      chk("fill_ready3", issue_ready3, 1);
      @(posedge clk); #2;
      chk("fill_pend_cnt3", pend_cnt3, d + 1);
      @(negedge clk);
    end
    issue_valid3 = 0;
    chk("full_busy3", busy3, 8'hFF);
    chk("full_pend_cnt3", pend_cnt3, 8);
    for (int d = 0; d < N3; d++) begin
      issue_addr3 = AW3'(d); src_a3 = AW3'((d + 3) % N3); src_b3 = AW3'((d + 5) % N3);
      #1;
      chk("full_ready3", issue_ready3, 0);
    end
    @(negedge clk);
    wb_valid3 = 1; wb_addr3 = 3'd2;
    @(posedge clk); #2;
    wb_valid3 = 0;
    chk("pulse_we3", we3, 8'h04);
    rst_n3 = 1'b0; #1;
    chk("rst_pulse_we3", we3, 0);
    chk("rst_pulse_busy3", busy3, 0);
    chk("rst_pulse_cnt3", pend_cnt3, 0);
    @(negedge clk); rst_n3 = 1'b1;
    issue_addr3 = 3'd7; src_a3 = 3'd0; src_b3 = 3'd3;
    #1;
    chk("post_rst_ready3", issue_ready3, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
